// File: rtl/memory_arbiter_if.sv
// Port bundle for memory_arbiter: the coherence-controller data port, two icache
// fetch ports and the single RAM port. The arbiter takes the slave view.
interface memory_arbiter_if;
  localparam int unsigned DW = 32;

  logic                   dREN;
  logic                   dWEN;
  logic [DW-1:0]          daddr;
  logic [DW-1:0]          dstore;
  logic                   dwait;
  logic [DW-1:0]          dload;

  logic [1:0]             iREN;
  logic [1:0][DW-1:0]     iaddr;
  logic [1:0]             iwait;
  logic [1:0][DW-1:0]     iload;

  logic                   ramREN;
  logic                   ramWEN;
  logic [DW-1:0]          ramaddr;
  logic [DW-1:0]          ramstore;
  logic [DW-1:0]          ramload;
  logic [1:0]             ramstate;

  modport slave (
    input  dREN, dWEN, daddr, dstore, iREN, iaddr, ramload, ramstate,
    output dwait, dload, iwait, iload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output dREN, dWEN, daddr, dstore, iREN, iaddr, ramload, ramstate,
    input  dwait, dload, iwait, iload, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/memory_arbiter.sv
// Serialises the data port and two icache fetch ports onto one RAM port:
// data first, round-robin between icaches, starvation counters bound icache delay.
module memory_arbiter #(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic            CLK,
  input  logic            nRST,
  memory_arbiter_if.slave io_bus
);

  localparam int unsigned   NI         = 2;
  localparam int unsigned   CW         = 8;
  localparam logic [CW-1:0] LIMIT      = CW'(STARVE_LIMIT);
  localparam logic [1:0]    RAM_ACCESS = 2'd2;

  typedef enum logic [1:0] {IDLE, DGNT, IGNT0, IGNT1} state_t;

  state_t                 r_state;
  state_t                 w_next_state;
  logic                   r_last_i;
  logic [NI-1:0][CW-1:0]  r_starve_cnt;
  logic [NI-1:0][CW-1:0]  w_starve_cnt_nxt;
  logic [NI-1:0]          w_starve;
  logic [NI-1:0]          w_idone;
  logic                   w_dreq;
  logic                   w_access;
  logic                   w_data_phase;
  logic                   w_rr_pick;

  assign w_dreq       = io_bus.dREN | io_bus.dWEN;
  assign w_access     = (io_bus.ramstate == RAM_ACCESS);
  assign w_data_phase = (r_state == DGNT) || ((r_state == IDLE) && w_dreq);
  // Round-robin favours the icache that was not served last.
  assign w_rr_pick    = ~r_last_i;

  // Per-icache completion and starvation bookkeeping
  for (genvar g = 0; g < NI; g++) begin : g_icache
    localparam state_t GNT_ST = (g == 0) ? IGNT0 : IGNT1;

    assign w_idone[g]  = (r_state == GNT_ST) && io_bus.iREN[g] && w_access;
    assign w_starve[g] = io_bus.iREN[g] && (r_starve_cnt[g] == LIMIT);
    assign w_starve_cnt_nxt[g] =
      (!io_bus.iREN[g] || w_idone[g])             ? '0 :
      (w_data_phase && (r_starve_cnt[g] != LIMIT)) ? r_starve_cnt[g] + CW'(1) :
                                                     r_starve_cnt[g];
  end

  // State register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Round-robin pointer and starvation counters
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_last_i     <= 1'b1;
      r_starve_cnt <= '0;
    end else begin
      r_starve_cnt <= w_starve_cnt_nxt;
      if (w_idone[0]) begin
        r_last_i <= 1'b0;
      end else if (w_idone[1]) begin
        r_last_i <= 1'b1;
      end
    end
  end

  // Next-state: arbitration in IDLE, release on completion or withdrawal
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (&w_starve) begin
          w_next_state = w_rr_pick ? IGNT1 : IGNT0;
        end else if (w_starve[0]) begin
          w_next_state = IGNT0;
        end else if (w_starve[1]) begin
          w_next_state = IGNT1;
        end else if (w_dreq) begin
          w_next_state = DGNT;
        end else if (&io_bus.iREN) begin
          w_next_state = w_rr_pick ? IGNT1 : IGNT0;
        end else if (io_bus.iREN[0]) begin
          w_next_state = IGNT0;
        end else if (io_bus.iREN[1]) begin
          w_next_state = IGNT1;
        end
      end
      DGNT: begin
        if (!w_dreq || w_access) begin
          w_next_state = IDLE;
        end
      end
      IGNT0: begin
        if (!io_bus.iREN[0] || w_access) begin
          w_next_state = IDLE;
        end
      end
      IGNT1: begin
        if (!io_bus.iREN[1] || w_access) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Outputs: RAM port follows the granted requester; waits drop only on completion
  always_comb begin
    io_bus.ramREN   = 1'b0;
    io_bus.ramWEN   = 1'b0;
    io_bus.ramaddr  = '0;
    io_bus.ramstore = '0;
    io_bus.dwait    = 1'b1;
    io_bus.dload    = '0;
    io_bus.iwait    = 2'b11;
    io_bus.iload    = '0;
    case (r_state)
      DGNT: begin
        io_bus.ramaddr = io_bus.daddr;
        if (w_dreq) begin
          if (io_bus.dWEN) begin
            io_bus.ramWEN   = 1'b1;
            io_bus.ramstore = io_bus.dstore;
          end else begin
            io_bus.ramREN = 1'b1;
          end
          if (w_access) begin
            io_bus.dwait = 1'b0;
            io_bus.dload = io_bus.dWEN ? '0 : io_bus.ramload;
          end
        end
      end
      IGNT0: begin
        io_bus.ramaddr = io_bus.iaddr[0];
        if (io_bus.iREN[0]) begin
          io_bus.ramREN = 1'b1;
          if (w_access) begin
            io_bus.iwait[0] = 1'b0;
            io_bus.iload[0] = io_bus.ramload;
          end
        end
      end
      IGNT1: begin
        io_bus.ramaddr = io_bus.iaddr[1];
        if (io_bus.iREN[1]) begin
          io_bus.ramREN = 1'b1;
          if (w_access) begin
            io_bus.iwait[1] = 1'b0;
            io_bus.iload[1] = io_bus.ramload;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Randomised and directed bench for memory_arbiter against a transaction-level
// owner/round-robin/starvation reference model.
`timescale 1ns/1ps
module tb_memory_arbiter;

  localparam int unsigned LIMIT = 8;
  localparam logic [1:0]  R_FREE = 2'd0, R_BUSY = 2'd1, R_ACC = 2'd2;

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  memory_arbiter_if bus ();
  memory_arbiter #(.STARVE_LIMIT(LIMIT)) dut (.CLK(CLK), .nRST(nRST), .io_bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  // Stimulus
  logic        s_dren, s_dwen;
  logic [31:0] s_daddr, s_dstore, s_ramload;
  logic [1:0]  s_iren, s_ramstate;
  logic [31:0] s_iaddr [2];

  // Reference model: who owns the RAM (-1 nobody, 0/1 icache, 2 data)
  int m_owner, m_last;
  int m_wait [2];

  // Expected outputs for the current cycle
  logic        e_ramren, e_ramwen, e_dwait;
  logic [31:0] e_addr, e_store, e_dload;
  logic [1:0]  e_iwait;
  logic [31:0] e_iload [2];
  bit          e_ddone;
  bit          e_idone [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last = 1;
    m_wait[0] = 0;
    m_wait[1] = 0;
  endtask

  task automatic model_expect();
    bit dreq, acc;
    dreq = s_dren | s_dwen;
    acc  = (s_ramstate == R_ACC);
    e_ramren = 0; e_ramwen = 0; e_addr = 0; e_store = 0;
    e_dwait = 1; e_dload = 0; e_iwait = 2'b11; e_iload[0] = 0; e_iload[1] = 0;
    e_ddone = 0; e_idone[0] = 0; e_idone[1] = 0;
    if (m_owner == 2) begin
      e_addr = s_daddr;
      if (dreq) begin
        if (s_dwen) begin e_ramwen = 1; e_store = s_dstore; end
        else e_ramren = 1;
        if (acc) begin
          e_dwait = 0; e_ddone = 1;
          e_dload = s_dwen ? 32'h0 : s_ramload;
        end
      end
    end else if (m_owner >= 0) begin
      e_addr = s_iaddr[m_owner];
      if (s_iren[m_owner]) begin
        e_ramren = 1;
        if (acc) begin
          e_iwait[m_owner] = 1'b0;
          e_iload[m_owner] = s_ramload;
          e_idone[m_owner] = 1;
        end
      end
    end
  endtask

  task automatic model_step();
    bit dreq, acc, data_phase;
    bit st [2];
    int nxt;
    dreq = s_dren | s_dwen;
    acc  = (s_ramstate == R_ACC);
    data_phase = (m_owner == 2) || (m_owner < 0 && dreq);
    for (int n = 0; n < 2; n++) st[n] = s_iren[n] && (m_wait[n] >= int'(LIMIT));
    nxt = m_owner;
    if (m_owner < 0) begin
      if (st[0] && st[1])       nxt = 1 - m_last;
      else if (st[0])           nxt = 0;
      else if (st[1])           nxt = 1;
      else if (dreq)            nxt = 2;
      else if (s_iren == 2'b11) nxt = 1 - m_last;
      else if (s_iren[0])       nxt = 0;
      else if (s_iren[1])       nxt = 1;
    end else if (m_owner == 2) begin
      if (!dreq || acc) nxt = -1;
    end else begin
      if (!s_iren[m_owner] || acc) nxt = -1;
      if (e_idone[m_owner]) m_last = m_owner;
    end
    for (int n = 0; n < 2; n++) begin
      if (!s_iren[n] || e_idone[n]) m_wait[n] = 0;
      else if (data_phase && m_wait[n] < int'(LIMIT)) m_wait[n]++;
    end
    m_owner = nxt;
  endtask

  task automatic check_outputs();
    check("ramREN",   32'(bus.ramREN),   32'(e_ramren));
    check("ramWEN",   32'(bus.ramWEN),   32'(e_ramwen));
    check("ramaddr",  bus.ramaddr,       e_addr);
    check("ramstore", bus.ramstore,      e_store);
    check("dwait",    32'(bus.dwait),    32'(e_dwait));
    check("dload",    bus.dload,         e_dload);
    check("iwait",    32'(bus.iwait),    32'(e_iwait));
    check("iload0",   bus.iload[0],      e_iload[0]);
    check("iload1",   bus.iload[1],      e_iload[1]);
  endtask

  task automatic apply();
    bus.dREN = s_dren; bus.dWEN = s_dwen; bus.daddr = s_daddr; bus.dstore = s_dstore;
    bus.iREN = s_iren; bus.iaddr[0] = s_iaddr[0]; bus.iaddr[1] = s_iaddr[1];
    bus.ramload = s_ramload; bus.ramstate = s_ramstate;
  endtask

  task automatic tick();
    @(negedge CLK);
    apply();
    #1;
    model_expect();
    check_outputs();
    model_step();
  endtask

  // Random requesters: hold a request until it completes, occasionally withdraw
  bit d_act;
  bit i_act [2];
  task automatic rand_drive();
    if (d_act && (e_ddone || $urandom_range(0, 49) == 0)) d_act = 0;
    if (!d_act && $urandom_range(0, 2) == 0) begin
      d_act = 1; s_daddr = $urandom; s_dstore = $urandom;
      case ($urandom_range(0, 2))
        0:       {s_dren, s_dwen} = 2'b10;
        1:       {s_dren, s_dwen} = 2'b01;
        default: {s_dren, s_dwen} = 2'b11;
      endcase
    end
    if (!d_act) {s_dren, s_dwen} = 2'b00;
    for (int n = 0; n < 2; n++) begin
      if (i_act[n] && (e_idone[n] || $urandom_range(0, 49) == 0)) i_act[n] = 0;
      if (!i_act[n] && $urandom_range(0, 1) == 0) begin
        i_act[n] = 1; s_iaddr[n] = $urandom;
      end
      s_iren[n] = i_act[n];
    end
    s_ramload  = $urandom;
    s_ramstate = ($urandom_range(0, 9) < 4) ? R_ACC : 2'($urandom_range(0, 3));
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, cnt2, first, second;
    int prev [2];
    s_dren = 0; s_dwen = 0; s_daddr = 0; s_dstore = 0; s_iren = 0;
    s_iaddr[0] = 32'h0000_1000; s_iaddr[1] = 32'h0000_2000;
    s_ramload = 0; s_ramstate = R_FREE;
    nRST = 0;
    apply();
    model_reset();
    #3;
    model_expect();
    check_outputs();
    repeat (2) @(posedge CLK);
    #2 nRST = 1;

    // Idle after reset
    repeat (10) tick();

    // Single read, ACCESS on the second grant cycle
    cnt = 0; cnt2 = 0;
    s_daddr = 32'h100; s_ramload = 32'hDEADBEEF;
    for (int c = 0; c < 4; c++) begin
      s_dren = (c < 3);
      s_ramstate = (c == 2) ? R_ACC : R_BUSY;
      tick();
      if (bus.ramREN) cnt++;
      if (!bus.dwait) begin
        cnt2++;
        check("rd_dload", bus.dload, 32'hDEADBEEF);
      end
    end
    check("rd_ren_cycles", 32'(cnt), 32'd2);
    check("rd_dwait_pulses", 32'(cnt2), 32'd1);

    // Both icaches held, RAM always ready: alternate 0,1,0,1 every 4 cycles
    s_iren = 2'b11; s_ramstate = R_ACC;
    prev[0] = -1; prev[1] = -1;
    for (int c = 1; c <= 16; c++) begin
      s_ramload = $urandom;
      tick();
      for (int n = 0; n < 2; n++) begin
        if (!bus.iwait[n]) begin
          if (prev[n] < 0) check($sformatf("rr_first%0d", n), 32'(c), 32'(2 + 2 * n));
          else check($sformatf("rr_gap%0d", n), 32'(c - prev[n]), 32'd4);
          prev[n] = c;
        end
      end
    end
    s_iren = 2'b00;
    repeat (2) tick();

    // Read and write together: write wins
    cnt = 0;
    s_dren = 1; s_dwen = 1; s_dstore = 32'h12345678; s_daddr = 32'h200;
    tick();
    tick();
    check("wr_ramWEN", 32'(bus.ramWEN), 32'd1);
    check("wr_ramREN", 32'(bus.ramREN), 32'd0);
    check("wr_ramstore", bus.ramstore, 32'h12345678);
    if (!bus.dwait) cnt++;
    s_dren = 0; s_dwen = 0;
    tick();
    if (!bus.dwait) cnt++;
    check("wr_dwait_pulses", 32'(cnt), 32'd1);

    // Continuous data traffic must not starve icache 0
    s_dren = 1; s_iren = 2'b01; s_ramstate = R_ACC;
    first = 99; second = 99;
    for (int c = 1; c <= 40; c++) begin
      if (c > 1 && bus.dwait == 1'b0) s_daddr = $urandom;
      tick();
      if (!bus.iwait[0]) begin
        if (first == 99) first = c;
        else if (second == 99) second = c;
      end
    end
    check("starve_lat1_le10", 32'(first <= 10), 32'd1);
    check("starve_lat2_le10", 32'(second - first <= 10), 32'd1);
    check("starve_cnt_cleared", 32'(second - first > 2), 32'd1);
    s_dren = 0; s_iren = 2'b00;
    repeat (2) tick();

    // Data withdrawn while BUSY
    cnt = 0;
    s_dren = 1; s_ramstate = R_BUSY;
    tick(); tick();
    if (!bus.dwait) cnt++;
    s_dren = 0;
    tick();
    if (!bus.dwait) cnt++;
    check("wd_ren_dropped", 32'(bus.ramREN), 32'd0);
    tick();
    if (!bus.dwait) cnt++;
    check("wd_dwait_pulses", 32'(cnt), 32'd0);

    // Async reset in the middle of an IGNT1 grant
    s_iren = 2'b10; s_iaddr[1] = 32'hABCD0000;
    tick(); tick();
    check("ig1_ramREN", 32'(bus.ramREN), 32'd1);
    nRST = 0;
    #1;
    check("rst_ramREN", 32'(bus.ramREN), 32'd0);
    check("rst_ramaddr", bus.ramaddr, 32'd0);
    check("rst_dwait", 32'(bus.dwait), 32'd1);
    check("rst_iwait", 32'(bus.iwait), 32'd3);
    check("rst_iload1", bus.iload[1], 32'd0);
    model_reset();
    @(posedge CLK);
    #2 nRST = 1;
    s_iren = 2'b11; s_ramstate = R_ACC;
    tick();
    check("post_rst_idle", 32'(bus.ramREN), 32'd0);
    tick();
    check("post_rst_win0_addr", bus.ramaddr, s_iaddr[0]);
    check("post_rst_win0_iwait", 32'(bus.iwait), 32'd2);
    s_iren = 2'b00;
    repeat (2) tick();

    // Random traffic against the model
    d_act = 0; i_act[0] = 0; i_act[1] = 0;
    e_ddone = 0; e_idone[0] = 0; e_idone[1] = 0;
    for (int c = 0; c < 2000; c++) begin
      rand_drive();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
